// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multi-cycle RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, decodes INST into
// every datapath select and enable, waits on IMEM/DMEM ready handshakes,
// counts retired instructions and parks in HALT on illegal opcodes or EBREAK.
module multicycle_ctrl #(
  parameter logic [2:0]  RESET_STATE = 3'd0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      INST,
  input  logic             BrEq,
  input  logic             BrLT,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             PCSel,
  output logic [2:0]       ImmSel,
  output logic             RegWEn,
  output logic             BrUn,
  output logic             ASel,
  output logic             BSel,
  output logic [3:0]       ALUControl,
  output logic             dmem_req,
  output logic             MemRW,
  output logic [1:0]       WBControl,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR,
    C_LUI, C_AUIPC, C_ECALL, C_ILLEGAL
  } cls_t;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [31:0]      ECALL_INSN = 32'h0000_0073;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  cls_t       cls;
  logic [3:0] alu_fn;
  logic       br_taken;

  logic       x_asel, x_bsel, x_brun;
  logic [2:0] x_imm;
  logic [3:0] x_alu;
  logic [1:0] x_wb;

  assign opcode   = INST[6:0];
  assign funct3   = INST[14:12];
  assign funct7_5 = INST[30];

  // Classify the opcode; EBREAK and every SYSTEM encoding other than ECALL halt.
  always_comb begin
    cls = C_ILLEGAL;
    case (opcode)
      7'b0110011: cls = C_R;
      7'b0010011: cls = C_IALU;
      7'b0000011: cls = C_LOAD;
      7'b0100011: cls = C_STORE;
      7'b1100011: cls = C_BRANCH;
      7'b1101111: cls = C_JAL;
      7'b1100111: cls = C_JALR;
      7'b0110111: cls = C_LUI;
      7'b0010111: cls = C_AUIPC;
      7'b1110011: cls = (INST == ECALL_INSN) ? C_ECALL : C_ILLEGAL;
      default:    cls = C_ILLEGAL;
    endcase
  end

  // ALU function from funct3; funct7[5] selects SUB only for R-type, SRA for both shifts.
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (cls == C_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  end

  // Branch decision from the datapath comparator; reserved funct3 values never branch.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:         br_taken = BrEq;
      3'b001:         br_taken = !BrEq;
      3'b100, 3'b110: br_taken = BrLT;
      3'b101, 3'b111: br_taken = !BrLT;
      default:        br_taken = 1'b0;
    endcase
  end

  // Datapath selects for the decoded class, held from EXEC through WB.
  always_comb begin
    x_asel = 1'b0;
    x_bsel = 1'b0;
    x_imm  = IMM_I;
    x_alu  = ALU_ADD;
    x_brun = 1'b0;
    x_wb   = WB_ALU;
    case (cls)
      C_R:    x_alu = alu_fn;
      C_IALU: begin
        x_bsel = 1'b1;
        x_alu  = alu_fn;
      end
      C_LOAD: begin
        x_bsel = 1'b1;
        x_wb   = WB_MEM;
      end
      C_STORE: begin
        x_bsel = 1'b1;
        x_imm  = IMM_S;
      end
      C_BRANCH: begin
        x_asel = 1'b1;
        x_bsel = 1'b1;
        x_imm  = IMM_B;
        x_brun = funct3[1];
      end
      C_JAL: begin
        x_asel = 1'b1;
        x_bsel = 1'b1;
        x_imm  = IMM_J;
        x_wb   = WB_PC4;
      end
      C_JALR: begin
        x_bsel = 1'b1;
        x_wb   = WB_PC4;
      end
      C_LUI: begin
        x_bsel = 1'b1;
        x_imm  = IMM_U;
        x_alu  = ALU_PASSB;
      end
      C_AUIPC: begin
        x_asel = 1'b1;
        x_bsel = 1'b1;
        x_imm  = IMM_U;
      end
      default: ;
    endcase
  end

  // Next state, retire count and all outputs, decoded from the current state and INST.
  always_comb begin
    state_d    = state_q;
    retired_d  = retired_q;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    PCSel      = 1'b0;
    ImmSel     = IMM_I;
    RegWEn     = 1'b0;
    BrUn       = 1'b0;
    ASel       = 1'b0;
    BSel       = 1'b0;
    ALUControl = ALU_ADD;
    dmem_req   = 1'b0;
    MemRW      = 1'b0;
    WBControl  = 2'b00;
    case (state_q)
      FETCH: begin
        // Gate with reset so the IR cannot be loaded while reset is held.
        ir_we = imem_ready & rst;
        if (imem_ready) state_d = DECODE;
      end
      DECODE: state_d = (cls == C_ILLEGAL) ? HALT : EXEC;
      EXEC: begin
        ImmSel     = x_imm;
        BrUn       = x_brun;
        ASel       = x_asel;
        BSel       = x_bsel;
        ALUControl = x_alu;
        WBControl  = x_wb;
        case (cls)
          C_BRANCH: begin
            pc_we     = 1'b1;
            PCSel     = !br_taken;
            retired_d = retired_q + CNT_ONE;
            state_d   = FETCH;
          end
          C_JAL, C_JALR: begin
            // Link register takes the old PC+4 on the same edge the PC moves.
            pc_we     = 1'b1;
            PCSel     = 1'b0;
            RegWEn    = 1'b1;
            retired_d = retired_q + CNT_ONE;
            state_d   = FETCH;
          end
          C_LOAD, C_STORE: state_d = MEM;
          default:         state_d = WB;
        endcase
      end
      MEM: begin
        ImmSel     = x_imm;
        ASel       = x_asel;
        BSel       = x_bsel;
        ALUControl = x_alu;
        WBControl  = x_wb;
        dmem_req   = 1'b1;
        MemRW      = (cls == C_STORE);
        if (dmem_ready) begin
          if (cls == C_STORE) begin
            pc_we     = 1'b1;
            PCSel     = 1'b1;
            retired_d = retired_q + CNT_ONE;
            state_d   = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        ImmSel     = x_imm;
        ASel       = x_asel;
        BSel       = x_bsel;
        ALUControl = x_alu;
        WBControl  = x_wb;
        RegWEn     = (cls != C_ECALL);
        pc_we      = 1'b1;
        PCSel      = 1'b1;
        retired_d  = retired_q + CNT_ONE;
        state_d    = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // State and retire counter; reset abandons any in-flight instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= state_t'(RESET_STATE);
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-scenario tasks with inline
// checks, plus a scoreboard of expected latency/retire count per instruction.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  // Masks over the packed control vector (bit order as in mk()).
  localparam logic [17:0] M_ALL = 18'h3FFFF;
  localparam logic [17:0] M_EX  = 18'h37BFC;  // no PCSel, BrUn, WBControl
  localparam logic [17:0] M_PC  = 18'h3FBFC;  // no BrUn, WBControl
  localparam logic [17:0] M_WB  = 18'h3FBFF;  // no BrUn
  localparam logic [17:0] M_BR  = 18'h3FFFC;  // no WBControl
  localparam logic [17:0] M_EN  = 18'h3080C;  // enables only

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   INST = 32'h0;
  logic          BrEq = 1'b0, BrLT = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic          ir_we, pc_we, PCSel, RegWEn, BrUn, ASel, BSel, dmem_req, MemRW, halted;
  logic [2:0]    ImmSel, state;
  logic [3:0]    ALUControl;
  logic [1:0]    WBControl;
  logic [CW-1:0] retired;
  logic [17:0]   ctl;

  multicycle_ctrl #(.RESET_STATE(3'd0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .INST(INST), .BrEq(BrEq), .BrLT(BrLT),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .PCSel(PCSel), .ImmSel(ImmSel),
    .RegWEn(RegWEn), .BrUn(BrUn), .ASel(ASel), .BSel(BSel),
    .ALUControl(ALUControl), .dmem_req(dmem_req), .MemRW(MemRW),
    .WBControl(WBControl), .halted(halted), .state(state), .retired(retired)
  );

  assign ctl = {ir_we, pc_we, PCSel, ImmSel, RegWEn, BrUn, ASel, BSel,
                ALUControl, dmem_req, MemRW, WBControl};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   inst;
    int            lat;
    logic [CW-1:0] ret;
    int            start;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [CW-1:0] exp_ret = '0;

  function automatic logic [17:0] mk(input logic ir, input logic pw, input logic ps,
                                     input logic [2:0] imm, input logic rw, input logic bu,
                                     input logic as, input logic bs, input logic [3:0] alu,
                                     input logic dr, input logic mw, input logic [1:0] wb);
    return {ir, pw, ps, imm, rw, bu, as, bs, alu, dr, mw, wb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present an instruction in FETCH; retiring ones get a scoreboard entry.
  task automatic issue(input logic [31:0] inst, input int lat, input bit retires);
    exp_t e;
    INST = inst;
    imem_ready = 1'b1;
    if (retires) begin
      exp_ret = exp_ret + 1'b1;
      e.inst = inst;
      e.lat = lat;
      e.ret = exp_ret;
      e.start = cyc;
      sb.push_back(e);
    end
    tick();
    imem_ready = 1'b0;
    #1;
  endtask

  task automatic wait_fetch(input int budget);
    int n = 0;
    while (state !== 3'd0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    INST = 32'h0050_0093;
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if ({state, retired, halted, ctl} !== {3'd0, {CW{1'b0}}, 1'b0, 18'h0}) begin
      n_errors++;
      $display("FAIL reset_async: state %0d retired %0d halted %0b ctl %h, expected 0 0 0 00000", state, retired, halted, ctl);
    end
    tick();
    tick();
    n_checks++;
    if ({state, retired, ctl & M_ALL} !== {3'd0, {CW{1'b0}}, 18'h0}) begin
      n_errors++;
      $display("FAIL reset_held: state %0d retired %0d ctl %h, expected 0 0 00000", state, retired, ctl);
    end
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    exp_ret = '0;
    #1;
  endtask

  task automatic test_addi();
    exp_t e;
    INST = 32'h0050_0093;
    imem_ready = 1'b1;
    #1;
    n_checks++;
    if ({state, ir_we} !== {3'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL addi_fetch: state %0d ir_we %0b, expected 0 1", state, ir_we);
    end
    issue(32'h0050_0093, 4, 1'b1);
    n_checks++;
    if ({state, ctl & M_EN} !== {3'd1, 18'h0}) begin
      n_errors++;
      $display("FAIL addi_decode: state %0d ctl %h, expected 1 enables 0", state, ctl);
    end
    tick();
    n_checks++;
    if ({state, ctl & M_EX} !== {3'd2, mk(0,0,0,3'd0,0,0,0,1,4'd0,0,0,2'b00) & M_EX}) begin
      n_errors++;
      $display("FAIL addi_exec: state %0d ctl %h, expected 2 %h", state, ctl & M_EX, mk(0,0,0,3'd0,0,0,0,1,4'd0,0,0,2'b00) & M_EX);
    end
    tick();
    n_checks++;
    if ({state, ctl & M_WB} !== {3'd4, mk(0,1,1,3'd0,1,0,0,1,4'd0,0,0,2'b01) & M_WB}) begin
      n_errors++;
      $display("FAIL addi_wb: state %0d ctl %h, expected 4 %h", state, ctl & M_WB, mk(0,1,1,3'd0,1,0,0,1,4'd0,0,0,2'b01) & M_WB);
    end
    tick();
    e = sb.pop_front();
    n_checks++;
    if ((cyc - e.start) != e.lat || retired !== e.ret || state !== 3'd0) begin
      n_errors++;
      $display("FAIL addi_retire: latency %0d retired %0d state %0d, expected %0d %0d 0", cyc - e.start, retired, state, e.lat, e.ret);
    end
  endtask

  task automatic test_load_wait();
    exp_t e;
    issue(32'h0000_A103, 8, 1'b1);
    tick();
    n_checks++;
    if ({state, ctl & M_EX} !== {3'd2, mk(0,0,0,3'd0,0,0,0,1,4'd0,0,0,2'b00) & M_EX}) begin
      n_errors++;
      $display("FAIL lw_exec: state %0d ctl %h", state, ctl & M_EX);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({state, ctl & M_EX} !== {3'd3, mk(0,0,0,3'd0,0,0,0,1,4'd0,1,0,2'b00) & M_EX}) begin
        n_errors++;
        $display("FAIL lw_mem_wait%0d: state %0d ctl %h", i, state, ctl & M_EX);
      end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    n_checks++;
    if ({state, ctl & M_EX} !== {3'd3, mk(0,0,0,3'd0,0,0,0,1,4'd0,1,0,2'b00) & M_EX}) begin
      n_errors++;
      $display("FAIL lw_mem_ready: state %0d ctl %h", state, ctl & M_EX);
    end
    tick();
    dmem_ready = 1'b0;
    #1;
    n_checks++;
    if ({state, ctl & M_WB} !== {3'd4, mk(0,1,1,3'd0,1,0,0,1,4'd0,0,0,2'b00) & M_WB}) begin
      n_errors++;
      $display("FAIL lw_wb: state %0d ctl %h, expected 4 %h", state, ctl & M_WB, mk(0,1,1,3'd0,1,0,0,1,4'd0,0,0,2'b00) & M_WB);
    end
    tick();
    e = sb.pop_front();
    n_checks++;
    if ((cyc - e.start) != e.lat || retired !== e.ret || state !== 3'd0) begin
      n_errors++;
      $display("FAIL lw_retire: latency %0d retired %0d state %0d, expected %0d %0d 0", cyc - e.start, retired, state, e.lat, e.ret);
    end
  endtask

  task automatic test_store();
    exp_t e;
    dmem_ready = 1'b1;
    issue(32'h0020_A023, 4, 1'b1);
    tick();
    n_checks++;
    if ({state, ctl & M_EX} !== {3'd2, mk(0,0,0,3'd1,0,0,0,1,4'd0,0,0,2'b00) & M_EX}) begin
      n_errors++;
      $display("FAIL sw_exec: state %0d ctl %h", state, ctl & M_EX);
    end
    tick();
    n_checks++;
    if ({state, ctl & M_PC} !== {3'd3, mk(0,1,1,3'd1,0,0,0,1,4'd0,1,1,2'b00) & M_PC}) begin
      n_errors++;
      $display("FAIL sw_mem: state %0d ctl %h, expected 3 %h", state, ctl & M_PC, mk(0,1,1,3'd1,0,0,0,1,4'd0,1,1,2'b00) & M_PC);
    end
    tick();
    dmem_ready = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if ((cyc - e.start) != e.lat || retired !== e.ret || state !== 3'd0) begin
      n_errors++;
      $display("FAIL sw_retire: latency %0d retired %0d state %0d, expected %0d %0d 0", cyc - e.start, retired, state, e.lat, e.ret);
    end
  endtask

  task automatic test_branch();
    logic [31:0] b_inst [4] = '{32'h0000_0463, 32'h0000_1463, 32'h0000_6463, 32'h0000_5463};
    logic        b_eq   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        b_lt   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        b_ps   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        b_un   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      BrEq = b_eq[i];
      BrLT = b_lt[i];
      issue(b_inst[i], 3, 1'b1);
      tick();
      n_checks++;
      if ({state, ctl & M_BR} !== {3'd2, mk(0,1,b_ps[i],3'd2,0,b_un[i],1,1,4'd0,0,0,2'b00) & M_BR}) begin
        n_errors++;
        $display("FAIL branch%0d_exec: state %0d ctl %h, expected 2 %h", i, state, ctl & M_BR, mk(0,1,b_ps[i],3'd2,0,b_un[i],1,1,4'd0,0,0,2'b00) & M_BR);
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if ((cyc - e.start) != e.lat || retired !== e.ret || state !== 3'd0) begin
        n_errors++;
        $display("FAIL branch%0d_retire: latency %0d retired %0d state %0d, expected %0d %0d 0", i, cyc - e.start, retired, state, e.lat, e.ret);
      end
    end
    BrEq = 1'b0;
    BrLT = 1'b0;
  endtask

  task automatic test_jump();
    logic [31:0] j_inst [2] = '{32'h0100_00EF, 32'h0000_80E7};
    logic [2:0]  j_imm  [2] = '{3'd4, 3'd0};
    logic        j_as   [2] = '{1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(j_inst[i], 3, 1'b1);
      tick();
      n_checks++;
      if ({state, ctl & M_WB} !== {3'd2, mk(0,1,0,j_imm[i],1,0,j_as[i],1,4'd0,0,0,2'b10) & M_WB}) begin
        n_errors++;
        $display("FAIL jump%0d_exec: state %0d ctl %h, expected 2 %h", i, state, ctl & M_WB, mk(0,1,0,j_imm[i],1,0,j_as[i],1,4'd0,0,0,2'b10) & M_WB);
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if ((cyc - e.start) != e.lat || retired !== e.ret || state !== 3'd0) begin
        n_errors++;
        $display("FAIL jump%0d_retire: latency %0d retired %0d state %0d, expected %0d %0d 0", i, cyc - e.start, retired, state, e.lat, e.ret);
      end
    end
  endtask

  task automatic test_alu_table();
    logic [31:0] t_inst [8] = '{32'h4020_8033, 32'h4020_D033, 32'h0020_F033, 32'h4010_D093,
                                32'h4000_0093, 32'h0010_C093, 32'h1234_50B7, 32'h0000_1097};
    logic [3:0]  t_alu  [8] = '{4'd1, 4'd7, 4'd9, 4'd7, 4'd0, 4'd5, 4'd10, 4'd0};
    logic [2:0]  t_imm  [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3};
    logic        t_as   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        t_bs   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [17:0] t_dc   [8] = '{18'h07000, 18'h07000, 18'h07000, 18'h0, 18'h0, 18'h0, 18'h00200, 18'h0};
    logic [17:0] mx, mw;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      mx = M_EX & ~t_dc[i];
      mw = M_WB & ~t_dc[i];
      issue(t_inst[i], 4, 1'b1);
      tick();
      n_checks++;
      if ({state, ctl & mx} !== {3'd2, mk(0,0,0,t_imm[i],0,0,t_as[i],t_bs[i],t_alu[i],0,0,2'b00) & mx}) begin
        n_errors++;
        $display("FAIL alu%0d_exec: inst %h state %0d ctl %h, expected 2 %h", i, t_inst[i], state, ctl & mx, mk(0,0,0,t_imm[i],0,0,t_as[i],t_bs[i],t_alu[i],0,0,2'b00) & mx);
      end
      tick();
      n_checks++;
      if ({state, ctl & mw} !== {3'd4, mk(0,1,1,t_imm[i],1,0,t_as[i],t_bs[i],t_alu[i],0,0,2'b01) & mw}) begin
        n_errors++;
        $display("FAIL alu%0d_wb: inst %h state %0d ctl %h, expected 4 %h", i, t_inst[i], state, ctl & mw, mk(0,1,1,t_imm[i],1,0,t_as[i],t_bs[i],t_alu[i],0,0,2'b01) & mw);
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if ((cyc - e.start) != e.lat || retired !== e.ret || state !== 3'd0) begin
        n_errors++;
        $display("FAIL alu%0d_retire: latency %0d retired %0d state %0d, expected %0d %0d 0", i, cyc - e.start, retired, state, e.lat, e.ret);
      end
    end
  endtask

  task automatic test_ecall();
    exp_t e;
    issue(32'h0000_0073, 4, 1'b1);
    tick();
    n_checks++;
    if ({state, ctl & M_EN} !== {3'd2, 18'h0}) begin
      n_errors++;
      $display("FAIL ecall_exec: state %0d ctl %h, expected 2 enables 0", state, ctl & M_EN);
    end
    tick();
    n_checks++;
    if ({state, ctl & (M_EN | 18'h08000)} !== {3'd4, mk(0,1,1,3'd0,0,0,0,0,4'd0,0,0,2'b00) & (M_EN | 18'h08000)}) begin
      n_errors++;
      $display("FAIL ecall_wb: state %0d ctl %h, expected 4 with RegWEn 0 pc_we 1 PCSel 1", state, ctl & (M_EN | 18'h08000));
    end
    tick();
    e = sb.pop_front();
    n_checks++;
    if ((cyc - e.start) != e.lat || retired !== e.ret || state !== 3'd0) begin
      n_errors++;
      $display("FAIL ecall_retire: latency %0d retired %0d state %0d, expected %0d %0d 0 (counter wraps)", cyc - e.start, retired, state, e.lat, e.ret);
    end
  endtask

  task automatic test_reset_mid_mem();
    issue(32'h0020_A023, 4, 1'b1);
    tick();
    tick();
    n_checks++;
    if ({state, dmem_req, MemRW, retired} !== {3'd3, 1'b1, 1'b1, exp_ret - 1'b1}) begin
      n_errors++;
      $display("FAIL midmem_pre: state %0d dmem_req %0b MemRW %0b retired %0d, expected 3 1 1 %0d", state, dmem_req, MemRW, retired, exp_ret - 1'b1);
    end
    rst = 1'b0;
    #1;
    sb.delete();
    exp_ret = '0;
    n_checks++;
    if ({state, retired, ctl} !== {3'd0, {CW{1'b0}}, 18'h0}) begin
      n_errors++;
      $display("FAIL midmem_reset: state %0d retired %0d ctl %h, expected 0 0 00000", state, retired, ctl);
    end
    tick();
    n_checks++;
    if ({state, retired, ctl} !== {3'd0, {CW{1'b0}}, 18'h0}) begin
      n_errors++;
      $display("FAIL midmem_held: state %0d retired %0d ctl %h, expected 0 0 00000", state, retired, ctl);
    end
    rst = 1'b1;
    #1;
  endtask

  task automatic test_halt();
    exp_t e;
    logic [31:0] h_inst [2] = '{32'hFFFF_FFFF, 32'h0010_0073};
    for (int k = 0; k < 2; k++) begin
      issue(32'h0050_0093, 4, 1'b1);
      wait_fetch(10);
      e = sb.pop_front();
      n_checks++;
      if ((cyc - e.start) != e.lat || retired !== e.ret) begin
        n_errors++;
        $display("FAIL halt%0d_pre_retire: latency %0d retired %0d, expected %0d %0d", k, cyc - e.start, retired, e.lat, e.ret);
      end
      issue(h_inst[k], 0, 1'b0);
      tick();
      n_checks++;
      if ({state, halted} !== {3'd5, 1'b1}) begin
        n_errors++;
        $display("FAIL halt%0d_enter: state %0d halted %0b, expected 5 1", k, state, halted);
      end
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        n_checks++;
        if ({state, halted, ctl & M_EN, retired} !== {3'd5, 1'b1, 18'h0, exp_ret}) begin
          n_errors++;
          $display("FAIL halt%0d_stay%0d: state %0d halted %0b ctl %h retired %0d, expected 5 1 0 %0d", k, i, state, halted, ctl & M_EN, retired, exp_ret);
        end
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      rst = 1'b0;
      #1;
      exp_ret = '0;
      n_checks++;
      if ({state, halted, retired} !== {3'd0, 1'b0, {CW{1'b0}}}) begin
        n_errors++;
        $display("FAIL halt%0d_exit: state %0d halted %0b retired %0d, expected 0 0 0", k, state, halted, retired);
      end
      tick();
      rst = 1'b1;
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_store();
    test_branch();
    test_jump();
    test_alu_table();
    test_ecall();
    test_reset_mid_mem();
    test_halt();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control unit sequencing the RV32I datapath (PC, IMEM, ImmGen, register file, ALU, data memory, writeback muxes) through fetch/decode/execute/memory/writeback states. Decodes INST and drives every datapath select and enable. Adds PC and IR write enables plus memory request/ready handshakes so IMEM/DMEM may take multiple cycles. Counts retired instructions and halts on illegal opcodes or EBREAK.

Parameters:
RESET_STATE, 3'd0, encoding of FETCH, also the reset state
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
INST  in  32  instruction register contents from the datapath
BrEq  in  1  comparator equal, from the datapath
BrLT  in  1  comparator less-than, from the datapath
imem_ready  in  1  IMEM data valid this cycle
dmem_ready  in  1  DMEM access complete this cycle
ir_we  out  1  load the instruction register
pc_we  out  1  load the PC
PCSel  out  1  0 = ALU_Result, 1 = PC+4
ImmSel  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J
RegWEn  out  1  register file write enable
BrUn  out  1  unsigned compare
ASel  out  1  0 = RD1, 1 = PC
BSel  out  1  0 = RD2, 1 = Imm
ALUControl  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
dmem_req  out  1  DMEM request, held until dmem_ready
MemRW  out  1  1 = write; valid only while dmem_req = 1
WBControl  out  2  bit0: 0 = ReadD, 1 = ALU; bit1: 1 = PC+4 overrides bit0
halted  out  1  controller is in HALT
state  out  3  current state, for debug
retired  out  CNT_W  count of completed instructions

Behaviour:
- States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5. Values 6 and 7 go to FETCH.
- Reset (rst = 0, asynchronous): state = FETCH, retired = 0. Every enable is 0 (ir_we, pc_we, RegWEn, dmem_req, MemRW). Every select is 0. A reset mid-instruction abandons that instruction with no writes.
- All outputs are decoded combinationally from the registered state and INST. Only state and retired are registered.
- FETCH:
  - imem_ready = 1: ir_we = 1, go to DECODE.
  - imem_ready = 0: hold in FETCH.
- DECODE:
  - Classify the opcode, then go to EXEC.
  - Illegal opcode, or EBREAK (INST = 0x00100073): go to HALT.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011 (ECALL only; EBREAK halts). ECALL is treated as a NOP.
- EXEC, per instruction class:
  - R-type: ASel = 0, BSel = 0. ALUControl from funct3 and funct7[5] (SUB/SRA when funct7[5] = 1). Go to WB.
  - I-ALU: ASel = 0, BSel = 1, ImmSel = I. funct7[5] is honoured only for SRAI. Go to WB.
  - Load/store: ADD, ASel = 0, BSel = 1, ImmSel = I (load) or S (store). Go to MEM.
  - Branch: ASel = 1, BSel = 1, ImmSel = B, ADD, BrUn = funct3[1].
    - Taken decision: BEQ = BrEq, BNE = !BrEq, BLT/BLTU = BrLT, BGE/BGEU = !BrLT.
    - pc_we = 1; PCSel = 0 if taken, else 1.
    - retired increments; go to FETCH. Total: 3 cycles.
  - JAL: ASel = 1, BSel = 1, ImmSel = J, ADD, PCSel = 0, pc_we = 1, RegWEn = 1, WBControl = 2'b10. RegWEn writes the old PC+4 on the same edge. retired increments; go to FETCH.
  - JALR: as JAL, but ASel = 0, ImmSel = I. The ALU result bit0 is cleared by the datapath.
  - LUI: BSel = 1, ImmSel = U, PASSB. Go to WB.
  - AUIPC: ASel = 1, BSel = 1, ImmSel = U, ADD. Go to WB.
  - ECALL: go to WB with RegWEn = 0.
- MEM: hold the EXEC ALU selects; dmem_req = 1; MemRW = 1 for store, 0 for load.
  - dmem_ready = 0: stay in MEM, holding all selects.
  - dmem_ready = 1, store: pc_we = 1, PCSel = 1, retired increments, go to FETCH.
  - dmem_ready = 1, load: go to WB.
- WB: hold the EXEC selects; RegWEn = 1 except ECALL; pc_we = 1, PCSel = 1; retired increments; go to FETCH.
  - Load: WBControl = 2'b00. Others: 2'b01.
- HALT: absorbing; halted = 1; no enables asserted. Exit only via reset.
- Latency with zero-wait memories:
  - ALU/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/JAL/JALR: 3 cycles.
- retired wraps modulo 2^CNT_W.
- dmem_ready outside MEM and imem_ready outside FETCH are ignored.

Test Plan:
- Reset, then INST = 0x00500093 (addi x1,x0,5) with imem_ready = 1 -> states 0,1,2,4. In WB: RegWEn = 1, WBControl = 01, BSel = 1, ALUControl = 0, pc_we = 1, PCSel = 1. retired = 1.
- INST = 0x0000A103 (lw x2,0(x1)), dmem_ready low for 3 cycles -> MEM held 4 cycles with dmem_req = 1, MemRW = 0. Then WB with WBControl = 00, RegWEn = 1. Total 8 cycles.
- INST = 0x0020A023 (sw x2,0(x1)) -> MEM with MemRW = 1, ImmSel = 1, RegWEn never asserted. Back in FETCH after 4 cycles.
- INST = 0x00000463 (beq x0,x0,8):
  - BrEq = 1 -> EXEC has pc_we = 1, PCSel = 0, ImmSel = 2.
  - Repeat with INST = 0x00001463 (bne) -> PCSel = 1.
- INST = 0x010000EF (jal x1,16) -> EXEC has RegWEn = 1, WBControl = 10, PCSel = 0, ImmSel = 4. Then INST = 0xFFFFFFFF -> HALT, halted = 1, retired frozen.
- Assert rst = 0 while in MEM with dmem_req = 1 -> immediately state = 0, dmem_req = 0, retired = 0, no write issued.
